bram_relu_writeback: RTL and testbench

- BRAM-port initiator that post-processes a convolution output region in place or into a second region.
- Uses the same 32-bit BRAM port as stdConv: byte address, word index in addr[12:2], one-cycle read latency, full-word writes with we=4'hF.
- Started and acknowledged over the same ps_control/pl_status start/done handshake that stdConv uses.
- Per word, reads SRC, applies ReLU (or a pass-through copy) and writes to DST, while counting the negative words it clamps.

---
 rtl/bram_relu_writeback.sv | 123 ++++++++++++
 tb/tb_bram_relu_writeback.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_relu_writeback.sv
// Post-processes a BRAM word region: each source word is read, optionally ReLU-clamped,
// and written to the destination region. Negative words clamped in ReLU mode are counted.
`timescale 1ns/1ps
module bram_relu_writeback #(
  parameter int SRC_BASE = 486,
  parameter int DST_BASE = 486,
  parameter int LENGTH   = 338
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ps_control,
  output logic [31:0] pl_status,
  output logic [31:0] BRAM_addr,
  input  logic [31:0] BRAM_rddata,
  output logic [31:0] BRAM_wrdata,
  output logic [3:0]  BRAM_we
);

  // States: IDLE wait start | RD source addr out | LAT read data valid | WR write dest | DONE hold done
  typedef enum logic [2:0] {IDLE, RD, LAT, WR, DONE} state_t;

  localparam logic [31:0] SRC  = 32'(SRC_BASE);
  localparam logic [31:0] DST  = 32'(DST_BASE);
  localparam logic [31:0] LAST = 32'(LENGTH) - 32'd1;

  state_t      state, state_d;
  logic        mode, mode_d;
  logic [31:0] idx, idx_d;
  logic [15:0] clamp, clamp_d;
  logic        done, done_d;
  logic        busy, busy_d;
  logic [31:0] addr_d, wrdata_d;
  logic [3:0]  we_d;
  logic        neg;

  // The write data is formed from the read word as it arrives, so it lands in the
  // output register at the same edge that enters WR.
  assign neg = ~mode & BRAM_rddata[31];

  always_comb begin
    state_d  = state;
    mode_d   = mode;
    idx_d    = idx;
    clamp_d  = clamp;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    addr_d   = BRAM_addr;
    wrdata_d = BRAM_wrdata;
    we_d     = 4'h0;
    case (state)
      IDLE: begin
        if (ps_control[0]) begin
          mode_d  = ps_control[1];
          idx_d   = 32'd0;
          clamp_d = 16'd0;
          if (LENGTH == 0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RD;
            busy_d  = 1'b1;
            addr_d  = SRC << 2;
          end
        end
      end
      RD: begin
        state_d = LAT;
        busy_d  = 1'b1;
      end
      LAT: begin
        state_d  = WR;
        busy_d   = 1'b1;
        addr_d   = (DST + idx) << 2;
        we_d     = 4'hF;
        wrdata_d = neg ? 32'd0 : BRAM_rddata;
        if (neg && clamp != 16'hFFFF) clamp_d = clamp + 16'd1;
      end
      WR: begin
        if (idx == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RD;
          busy_d  = 1'b1;
          idx_d   = idx + 32'd1;
          addr_d  = (SRC + idx + 32'd1) << 2;
        end
      end
      DONE: begin
        if (ps_control[0]) done_d = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode        <= 1'b0;
      idx         <= 32'd0;
      clamp       <= 16'd0;
      done        <= 1'b0;
      busy        <= 1'b0;
      BRAM_addr   <= 32'd0;
      BRAM_wrdata <= 32'd0;
      BRAM_we     <= 4'h0;
    end else begin
      state       <= state_d;
      mode        <= mode_d;
      idx         <= idx_d;
      clamp       <= clamp_d;
      done        <= done_d;
      busy        <= busy_d;
      BRAM_addr   <= addr_d;
      BRAM_wrdata <= wrdata_d;
      BRAM_we     <= we_d;
    end
  end

  assign pl_status = {clamp, 14'd0, busy, done};

endmodule

// File: tb/tb_bram_relu_writeback.sv
// Bench for bram_relu_writeback: three instances (in-place ReLU, copy to region 0, empty run)
// with behavioural BRAMs, a reference model over plain arrays, and a bus monitor.
`timescale 1ns/1ps
module tb_bram_relu_writeback;

  localparam int SRC = 486;
  localparam int LEN = 338;
  localparam logic [31:0] OFF_B = 32'(0 - SRC * 4);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ctl_a, ctl_b, ctl_c;
  logic [31:0] st_a, st_b, st_c;
  logic [31:0] addr_a, addr_b, addr_c;
  logic [31:0] wr_a, wr_b, wr_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic [3:0]  we_a, we_b, we_c;

  bit [31:0] mem_a [0:2047];
  bit [31:0] mem_b [0:2047];
  bit [31:0] mem_c [0:2047];
  bit [31:0] img   [0:2047];
  bit [31:0] exp_m [0:2047];

  int        pl_sel;
  logic      pl_en;
  logic [10:0] pl_addr;
  logic [31:0] pl_data;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt_a = 0, we_cnt_b = 0, we_cnt_c = 0;
  logic [31:0] last_rd_a = 0, last_rd_b = 0;

  always #5 clk = ~clk;

  bram_relu_writeback #(.SRC_BASE(SRC), .DST_BASE(SRC), .LENGTH(LEN)) dut_a (
    .clk(clk), .reset(reset), .ps_control(ctl_a), .pl_status(st_a),
    .BRAM_addr(addr_a), .BRAM_rddata(rd_a), .BRAM_wrdata(wr_a), .BRAM_we(we_a));
  bram_relu_writeback #(.SRC_BASE(SRC), .DST_BASE(0), .LENGTH(LEN)) dut_b (
    .clk(clk), .reset(reset), .ps_control(ctl_b), .pl_status(st_b),
    .BRAM_addr(addr_b), .BRAM_rddata(rd_b), .BRAM_wrdata(wr_b), .BRAM_we(we_b));
  bram_relu_writeback #(.SRC_BASE(SRC), .DST_BASE(SRC), .LENGTH(0)) dut_c (
    .clk(clk), .reset(reset), .ps_control(ctl_c), .pl_status(st_c),
    .BRAM_addr(addr_c), .BRAM_rddata(rd_c), .BRAM_wrdata(wr_c), .BRAM_we(we_c));

  always @(posedge clk) begin
    if (pl_en && pl_sel == 0) mem_a[pl_addr] <= pl_data;
    else if (we_a == 4'hF) mem_a[addr_a[12:2]] <= wr_a;
    rd_a <= mem_a[addr_a[12:2]];
  end
  always @(posedge clk) begin
    if (pl_en && pl_sel == 1) mem_b[pl_addr] <= pl_data;
    else if (we_b == 4'hF) mem_b[addr_b[12:2]] <= wr_b;
    rd_b <= mem_b[addr_b[12:2]];
  end
  always @(posedge clk) begin
    if (pl_en && pl_sel == 2) mem_c[pl_addr] <= pl_data;
    else if (we_c == 4'hF) mem_c[addr_c[12:2]] <= wr_c;
    rd_c <= mem_c[addr_c[12:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("we_legal_a", 32'(we_a == 4'h0 || we_a == 4'hF), 32'd1);
      chk("align_a", 32'(addr_a[1:0]), 32'd0);
      chk("we_legal_b", 32'(we_b == 4'h0 || we_b == 4'hF), 32'd1);
      chk("align_b", 32'(addr_b[1:0]), 32'd0);
      if (we_a == 4'hF) begin
        we_cnt_a++;
        chk("wr_addr_a", addr_a, last_rd_a);
      end else last_rd_a = addr_a;
      if (we_b == 4'hF) begin
        we_cnt_b++;
        chk("wr_addr_b", addr_b, last_rd_b + OFF_B);
      end else last_rd_b = addr_b;
      if (we_c != 4'h0) we_cnt_c++;
    end
  end

  function automatic logic [31:0] status_of(input int sel);
    case (sel)
      0: return st_a;
      1: return st_b;
      default: return st_c;
    endcase
  endfunction

  function automatic logic [31:0] mem_of(input int sel, input int w);
    case (sel)
      0: return mem_a[w];
      1: return mem_b[w];
      default: return mem_c[w];
    endcase
  endfunction

  task automatic set_ctl(input int sel, input logic [31:0] v);
    case (sel)
      0: ctl_a = v;
      1: ctl_b = v;
      default: ctl_c = v;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Words 0..449 = 1..450, 450..485 = 3.., output region zero or random.
  task automatic load(input int sel, input bit rnd);
    pl_sel = sel;
    for (int w = 0; w < SRC + LEN; w++) begin
      logic [31:0] v;
      if (w < 450) v = 32'(w + 1);
      else if (w < SRC) v = 32'(3 + w - 450);
      else if (rnd) v = $urandom;
      else v = 32'd0;
      if (!rnd && w == SRC) v = 32'hFFFFFFF6;
      if (!rnd && w == SRC + 1) v = 32'd25;
      if (!rnd && w == SRC + LEN - 1) v = 32'h80000000;
      img[w]  = v;
      pl_en   = 1'b1;
      pl_addr = 11'(w);
      pl_data = v;
      step();
    end
    pl_en = 1'b0;
  endtask

  task automatic run(input int sel, input logic mode, input bit toggle, output int lat);
    set_ctl(sel, {30'd0, mode, 1'b1});
    lat = 0;
    do begin
      step();
      lat++;
      if (toggle && lat == 5) begin
        chk("busy_mid", 32'(status_of(sel)[1]), 32'd1);
        set_ctl(sel, 32'h2);
      end
    end while (!status_of(sel)[0] && lat < 2000);
  endtask

  task automatic release_start(input int sel);
    set_ctl(sel, 32'd0);
    step();
  endtask

  task automatic check_region(input int sel, input int lo, input int hi, input string tag);
    for (int w = lo; w <= hi; w++)
      chk($sformatf("%s[%0d]", tag, w), mem_of(sel, w), exp_m[w]);
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
    return v[31] ? 32'd0 : v;
  endfunction

  initial begin
    int lat;
    int negs;
    bit found;
    reset = 1'b1;
    ctl_a = 0; ctl_b = 0; ctl_c = 0;
    pl_en = 0; pl_sel = 0; pl_addr = 0; pl_data = 0;
    #1;
    chk("rst_status", st_a, 32'd0);
    chk("rst_addr", addr_a, 32'd0);
    chk("rst_wrdata", wr_a, 32'd0);
    chk("rst_we", 32'(we_a), 32'd0);
    step(); step();
    reset = 1'b0;
    step();
    chk("idle_status", st_a, 32'd0);

    // In-place ReLU on the directed image.
    load(0, 1'b0);
    for (int w = 0; w < SRC + LEN; w++) exp_m[w] = (w >= SRC) ? relu(img[w]) : img[w];
    run(0, 1'b0, 1'b0, lat);
    chk("relu_latency", 32'(lat), 32'(3 * LEN + 1));
    chk("relu_m486", mem_a[486], 32'd0);
    chk("relu_m487", mem_a[487], 32'd25);
    chk("relu_m823", mem_a[823], 32'd0);
    check_region(0, 0, SRC + LEN - 1, "relu_mem");
    chk("relu_count", 32'(st_a[31:16]), 32'd2);
    chk("relu_busy_done", 32'(st_a[1:0]), 32'h1);
    chk("relu_we_pulses", 32'(we_cnt_a), 32'(LEN));

    // Held start must not retrigger.
    for (int k = 0; k < 50; k++) step();
    chk("hold_done", 32'(st_a[0]), 32'd1);
    chk("hold_no_rerun", 32'(we_cnt_a), 32'(LEN));
    release_start(0);
    chk("release_done", 32'(st_a[0]), 32'd0);
    chk("release_count", 32'(st_a[31:16]), 32'd2);

    // Copy mode into region 0.
    load(1, 1'b0);
    for (int w = 0; w < SRC + LEN; w++) exp_m[w] = (w < LEN) ? img[w + SRC] : img[w];
    run(1, 1'b1, 1'b0, lat);
    chk("copy_latency", 32'(lat), 32'(3 * LEN + 1));
    chk("copy_m0", mem_b[0], 32'hFFFFFFF6);
    chk("copy_m1", mem_b[1], 32'd25);
    check_region(1, 0, SRC + LEN - 1, "copy_mem");
    chk("copy_count", 32'(st_b[31:16]), 32'd0);
    release_start(1);

    // Empty run.
    run(2, 1'b0, 1'b0, lat);
    chk("len0_latency", 32'(lat), 32'd1);
    chk("len0_status", st_c, 32'h1);
    release_start(2);
    chk("len0_we_pulses", 32'(we_cnt_c), 32'd0);

    // Random data; start dropped and mode flipped mid-run must be ignored.
    load(0, 1'b1);
    negs = 0;
    for (int w = 0; w < SRC + LEN; w++) begin
      exp_m[w] = (w >= SRC) ? relu(img[w]) : img[w];
      if (w >= SRC && img[w][31]) negs++;
    end
    run(0, 1'b0, 1'b1, lat);
    chk("rand_latency", 32'(lat), 32'(3 * LEN + 1));
    check_region(0, SRC, SRC + LEN - 1, "rand_mem");
    chk("rand_count", 32'(st_a[31:16]), 32'(negs));
    step();
    chk("rand_back_idle", 32'(st_a[1:0]), 32'd0);

    // Asynchronous reset during the write of word 100, then a full rerun.
    load(0, 1'b1);
    set_ctl(0, 32'h1);
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      step();
      if (we_a == 4'hF && addr_a == 32'((SRC + 100) * 4)) found = 1'b1;
    end
    chk("reach_wr100", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_status", st_a, 32'd0);
    chk("arst_addr", addr_a, 32'd0);
    chk("arst_wrdata", wr_a, 32'd0);
    chk("arst_we", 32'(we_a), 32'd0);
    step();
    reset = 1'b0;
    set_ctl(0, 32'd0);
    step();
    chk("arst_no_write", mem_a[SRC + 100], img[SRC + 100]);
    negs = 0;
    for (int w = 0; w < SRC + LEN; w++) begin
      exp_m[w] = (w >= SRC) ? relu(img[w]) : img[w];
      if (w >= SRC + 100 && img[w][31]) negs++;
    end
    we_cnt_a = 0;
    run(0, 1'b0, 1'b0, lat);
    chk("rerun_latency", 32'(lat), 32'(3 * LEN + 1));
    check_region(0, 0, SRC + LEN - 1, "rerun_mem");
    chk("rerun_count", 32'(st_a[31:16]), 32'(negs));
    chk("rerun_we_pulses", 32'(we_cnt_a), 32'(LEN));
    release_start(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
